mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single memory port between the instruction-fetch requester and a data load/store requester. Sits between fetch/LSU and memory; owns memory addr, data, read-enable and write-enable. One transaction outstanding at a time, with fixed read latency. Data port has priority, bounded by a fetch-starvation counter.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
READ_LAT, 1, cycles from memory read-enable to valid mem_rdata_i (>=1)
STARVE_MAX, 4, consecutive fetch-losing arbitrations before fetch is forced to win (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
if_req_valid_i  in  1  fetch read request
if_req_addr_i  in  AWIDTH  fetch address
if_req_ready_o  out  1  fetch request accepted when valid&&ready
if_rsp_valid_o  out  1  fetch read data valid, 1-cycle pulse
if_rsp_data_o  out  DWIDTH  fetch read data
d_req_valid_i  in  1  data request
d_req_we_i  in  1  1=write, 0=read
d_req_addr_i  in  AWIDTH  data address
d_req_wdata_i  in  DWIDTH  write data
d_req_ready_o  out  1  data request accepted when valid&&ready
d_rsp_valid_o  out  1  read data / write ack, 1-cycle pulse
d_rsp_data_o  out  DWIDTH  read data; 0 for write ack
mem_addr_o  out  AWIDTH  memory address
mem_wdata_o  out  DWIDTH  memory write data
mem_read_en_o  out  1  memory read strobe
mem_write_en_o  out  1  memory write strobe
mem_rdata_i  in  DWIDTH  memory read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, starve_cnt 0, latency counter 0, all outputs 0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: readies combinational, asserted only in IDLE. Winner selection:
  - d wins if d_req_valid_i and not (if_req_valid_i && starve_cnt==STARVE_MAX).
  - Otherwise fetch wins if if_req_valid_i.
  - Only the winner's ready is high; loser sees ready=0 and must hold its request.
  - On accept: register owner, we, addr, wdata; go to ACCESS.
- starve_cnt: +1 on each accept where d wins while if_req_valid_i=1 (saturates at STARVE_MAX); cleared when fetch is accepted; otherwise held.
- ACCESS (1 cycle): drive mem_addr_o/mem_wdata_o from registers. Assert exactly one of mem_read_en_o / mem_write_en_o for this cycle.
  - Write: go to RESP.
  - Read: load latency counter with READ_LAT-1; go to WAIT if READ_LAT>1, else RESP.
- WAIT: decrement each cycle; at 0 go to RESP. Memory strobes 0; mem_addr_o held.
- RESP (1 cycle): owner's rsp_valid=1.
  - Read: rsp_data = mem_rdata_i, sampled this cycle.
  - Write: d_rsp_data_o=0.
  - Non-owner rsp_valid=0. Next state IDLE.
- No response backpressure; requesters must accept the pulse.
- Latency from accept edge to rsp_valid:
  - Read: READ_LAT+1 cycles.
  - Write: 2 cycles.
- Back-to-back throughput: one transaction per READ_LAT+2 cycles (read), 3 cycles (write).
- Simultaneous valid on both ports with starve_cnt<STARVE_MAX: d wins.
- Valid deasserted before accept is legal (request withdrawn); no side effect.
- Inputs are ignored outside IDLE; requests change only the next arbitration.
- Reset mid-transaction: in-flight transaction dropped; no rsp pulse is produced after reset release.
- Addresses and data pass through unmodified; no alignment checks.
- mem_addr_o/mem_wdata_o are registered; memory strobes never assert in IDLE or RESP.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, WAIT, RESP) and owner enum (OWN_IF, OWN_D).
- Single module, no sub-module; starvation counter and latency counter are inline.

Test Plan:
- Single fetch read at addr 0x100, READ_LAT=1, memory returns 0x00000013 -> accept in cycle 0; mem_read_en_o=1 with mem_addr_o=0x100 in cycle 1; if_rsp_valid_o=1, data 0x13 in cycle 2; busy_o=0 in cycle 3.
- Data write addr 0x200, wdata 0xDEADBEEF -> mem_write_en_o=1 exactly one cycle with that addr/data; d_rsp_valid_o=1, d_rsp_data_o=0 two cycles after accept; mem_read_en_o never high.
- Both ports valid continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; starve_cnt returns to 0 after each IF grant.
- READ_LAT=3, data read 0x40 returning 0xCAFEF00D -> d_rsp_valid_o exactly 4 cycles after accept with 0xCAFEF00D; if_req_ready_o stays 0 throughout despite fetch valid.
- Assert rst=0 during WAIT of a fetch read, release after 2 cycles -> all outputs 0 immediately (async); no if_rsp_valid_o pulse afterwards; a new fetch is accepted the first cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: controller states and
// transaction owner encoding.
package mem_arb_pkg;

  // Controller states. Only IDLE accepts requests; ACCESS is the single
  // strobe cycle, WAIT covers the remaining read latency and RESP returns
  // the response pulse to the owner.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave  : arbiter view (consumes requests, drives responses and memory)
// master : environment view (requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  // Fetch requester
  logic              if_req_valid_i;
  logic [AWIDTH-1:0] if_req_addr_i;
  logic              if_req_ready_o;
  logic              if_rsp_valid_o;
  logic [DWIDTH-1:0] if_rsp_data_o;

  // Data (load/store) requester
  logic              d_req_valid_i;
  logic              d_req_we_i;
  logic [AWIDTH-1:0] d_req_addr_i;
  logic [DWIDTH-1:0] d_req_wdata_i;
  logic              d_req_ready_o;
  logic              d_rsp_valid_o;
  logic [DWIDTH-1:0] d_rsp_data_o;

  // Memory port
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_wdata_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_rdata_i;

  // Status
  logic              busy_o;

  modport slave (
    input  if_req_valid_i, if_req_addr_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    input  d_req_valid_i, d_req_we_i, d_req_addr_i, d_req_wdata_i,
    output d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
    output mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_valid_i, if_req_addr_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    output d_req_valid_i, d_req_we_i, d_req_addr_i, d_req_wdata_i,
    input  d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
    input  mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o,
    output mem_rdata_i,
    input  busy_o
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and the data
// load/store unit. One transaction in flight, fixed read latency, data side
// preferred unless fetch has lost STARVE_MAX consecutive arbitrations.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [LW-1:0] LAT_LOAD  = LW'(READ_LAT - 1);
  localparam logic [SW-1:0] STARVE_HI = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [LW-1:0]     lat_q, lat_d;

  logic              force_if;

  // State and transaction registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
    end
  end

  // Fetch is forced to win once it has been starved to the limit.
  always_comb begin
    force_if = bus.if_req_valid_i && (starve_q == STARVE_HI);
  end

  // Next-state logic: arbitration and readies in IDLE, sequencing afterwards.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    we_d              = we_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    starve_d          = starve_q;
    lat_d             = lat_q;
    bus.if_req_ready_o = 1'b0;
    bus.d_req_ready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.d_req_valid_i && !force_if) begin
          bus.d_req_ready_o = 1'b1;
          owner_d           = OWN_D;
          we_d              = bus.d_req_we_i;
          addr_d            = bus.d_req_addr_i;
          wdata_d           = bus.d_req_wdata_i;
          state_d           = ACCESS;
          if (bus.if_req_valid_i && (starve_q != STARVE_HI)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (bus.if_req_valid_i) begin
          bus.if_req_ready_o = 1'b1;
          owner_d            = OWN_IF;
          we_d               = 1'b0;
          addr_d             = bus.if_req_addr_i;
          starve_d           = '0;
          state_d            = ACCESS;
        end
      end

      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = (READ_LAT > 1) ? WAIT : RESP;
        end
      end

      // The counter holds the cycles still to wait including this one; leave
      // when it would reach zero so that RESP lands READ_LAT cycles after the
      // read strobe, which is when the memory data is valid.
      WAIT: begin
        lat_d = lat_q - LW'(1);
        if (lat_q <= LW'(1)) begin
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state; memory address/data come straight
  // from the transaction registers.
  always_comb begin
    bus.mem_addr_o     = addr_q;
    bus.mem_wdata_o    = wdata_q;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    bus.if_rsp_valid_o = 1'b0;
    bus.if_rsp_data_o  = '0;
    bus.d_rsp_valid_o  = 1'b0;
    bus.d_rsp_data_o   = '0;
    bus.busy_o         = (state_q != IDLE);

    if (state_q == ACCESS) begin
      bus.mem_read_en_o  = !we_q;
      bus.mem_write_en_o = we_q;
    end

    if (state_q == RESP) begin
      if (owner_q == OWN_IF) begin
        bus.if_rsp_valid_o = 1'b1;
        bus.if_rsp_data_o  = bus.mem_rdata_i;
      end else begin
        bus.d_rsp_valid_o = 1'b1;
        bus.d_rsp_data_o  = we_q ? '0 : bus.mem_rdata_i;
      end
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (READ_LAT=1 and READ_LAT=3) with
// latency-accurate memory models and a response scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst1 = 1'b0;
  logic rst3 = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) b1();
  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) b3();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .READ_LAT(1), .STARVE_MAX(4))
    u1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .READ_LAT(3), .STARVE_MAX(4))
    u3 (.clk(clk), .rst(rst3), .bus(b3));

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    if (a == 32'h40)  return 32'hCAFE_F00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: data valid exactly READ_LAT cycles after the read strobe,
  // garbage otherwise so a mistimed sample is caught.
  logic [31:0] m1_q;
  logic [31:0] m3_q [3];
  always @(posedge clk) m1_q <= b1.mem_read_en_o ? memval(b1.mem_addr_o) : 32'h0BAD_0BAD;
  always @(posedge clk) begin
    m3_q[0] <= b3.mem_read_en_o ? memval(b3.mem_addr_o) : 32'h0BAD_0BAD;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign b1.mem_rdata_i = m1_q;
  assign b3.mem_rdata_i = m3_q[2];

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic test_reset();
    #1;
    tests++;
    if ({b1.busy_o, b1.mem_read_en_o, b1.mem_write_en_o, b1.if_rsp_valid_o, b1.d_rsp_valid_o,
         b1.if_req_ready_o, b1.d_req_ready_o, b1.mem_addr_o, b1.mem_wdata_o,
         b1.if_rsp_data_o, b1.d_rsp_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_u1: busy=%b rd=%b wr=%b addr=%h required all zero",
               b1.busy_o, b1.mem_read_en_o, b1.mem_write_en_o, b1.mem_addr_o);
    end
    tests++;
    if ({b3.busy_o, b3.mem_read_en_o, b3.mem_write_en_o, b3.if_rsp_valid_o, b3.d_rsp_valid_o,
         b3.if_req_ready_o, b3.d_req_ready_o, b3.mem_addr_o, b3.mem_wdata_o,
         b3.if_rsp_data_o, b3.d_rsp_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_u3: busy=%b rd=%b wr=%b addr=%h required all zero",
               b3.busy_o, b3.mem_read_en_o, b3.mem_write_en_o, b3.mem_addr_o);
    end
    @(negedge clk);
    rst1 = 1'b1;
    rst3 = 1'b1;
  endtask

  task automatic test_single_fetch();
    int c, n;
    exp_t e;
    @(negedge clk);
    b1.if_req_valid_i = 1'b1;
    b1.if_req_addr_i  = 32'h100;
    #1;
    n = 0;
    while (!b1.if_req_ready_o && n < 20) begin @(negedge clk); #1; n++; end
    tests++;
    if (b1.if_req_ready_o !== 1'b1) begin
      fails++; $display("FAIL fetch_accept: ready=%b required 1", b1.if_req_ready_o);
    end
    c = cyc;
    sb.push_back('{OWN_IF, memval(32'h100), c + 2});
    @(negedge clk); #1;
    b1.if_req_valid_i = 1'b0;
    tests++;
    if ({b1.mem_read_en_o, b1.mem_write_en_o, b1.mem_addr_o} !== {1'b1, 1'b0, 32'h100}) begin
      fails++;
      $display("FAIL fetch_strobe: rd=%b wr=%b addr=%h required rd=1 wr=0 addr=100",
               b1.mem_read_en_o, b1.mem_write_en_o, b1.mem_addr_o);
    end
    n = 0;
    while (!b1.if_rsp_valid_o && n < 10) begin @(negedge clk); #1; n++; end
    e = sb.size() ? sb.pop_front() : '{OWN_D, 32'h0, -1};
    tests++;
    if (!b1.if_rsp_valid_o || cyc != e.due || b1.if_rsp_data_o !== e.data || b1.d_rsp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL fetch_rsp: valid=%b cycle=%0d data=%h required valid=1 cycle=%0d data=%h",
               b1.if_rsp_valid_o, cyc, b1.if_rsp_data_o, e.due, e.data);
    end
    @(negedge clk); #1;
    tests++;
    if ({b1.busy_o, b1.if_rsp_valid_o} !== 2'b00) begin
      fails++; $display("FAIL fetch_idle: busy=%b rsp=%b required 0 0", b1.busy_o, b1.if_rsp_valid_o);
    end
  endtask

  task automatic test_write();
    int c, n, wr_cnt, rd_cnt;
    logic ok_strobe, ok_rsp;
    @(negedge clk);
    b1.d_req_valid_i = 1'b1;
    b1.d_req_we_i    = 1'b1;
    b1.d_req_addr_i  = 32'h200;
    b1.d_req_wdata_i = 32'hDEAD_BEEF;
    #1;
    n = 0;
    while (!b1.d_req_ready_o && n < 20) begin @(negedge clk); #1; n++; end
    tests++;
    if (b1.d_req_ready_o !== 1'b1) begin
      fails++; $display("FAIL write_accept: ready=%b required 1", b1.d_req_ready_o);
    end
    c = cyc;
    wr_cnt = 0; rd_cnt = 0; ok_strobe = 1'b0; ok_rsp = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      if (k == 1) b1.d_req_valid_i = 1'b0;
      if (b1.mem_write_en_o) wr_cnt++;
      if (b1.mem_read_en_o)  rd_cnt++;
      if (k == 1 && b1.mem_write_en_o && b1.mem_addr_o == 32'h200 && b1.mem_wdata_o == 32'hDEAD_BEEF)
        ok_strobe = 1'b1;
      if (b1.d_rsp_valid_o && cyc == c + 2 && b1.d_rsp_data_o === 32'h0) ok_rsp = 1'b1;
    end
    tests++;
    if (!ok_strobe || wr_cnt != 1 || rd_cnt != 0) begin
      fails++;
      $display("FAIL write_strobe: ok=%b wr_cycles=%0d rd_cycles=%0d required ok=1 wr=1 rd=0",
               ok_strobe, wr_cnt, rd_cnt);
    end
    tests++;
    if (!ok_rsp) begin
      fails++; $display("FAIL write_ack: seen=%b required ack with data 0 at accept+2", ok_rsp);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] got;
    logic [9:0] expv;
    int g, n;
    exp_t e;
    expv = 10'b0111101111;  // bit i = 1 when grant i goes to data
    got = '0;
    g = 0;
    sb.delete();
    @(negedge clk);
    b1.if_req_valid_i = 1'b1;
    b1.if_req_addr_i  = 32'h300;
    b1.d_req_valid_i  = 1'b1;
    b1.d_req_we_i     = 1'b0;
    b1.d_req_addr_i   = 32'h400;
    n = 0;
    while ((g < 10 || sb.size() != 0) && n < 300) begin
      #1;
      if (g >= 10) begin b1.if_req_valid_i = 1'b0; b1.d_req_valid_i = 1'b0; end
      if (b1.if_rsp_valid_o || b1.d_rsp_valid_o) begin
        e = sb.size() ? sb.pop_front() : '{OWN_IF, 32'h0, -1};
        tests++;
        if ((e.own == OWN_D ? b1.d_rsp_valid_o : b1.if_rsp_valid_o) !== 1'b1 || cyc != e.due ||
            (e.own == OWN_D ? b1.d_rsp_data_o : b1.if_rsp_data_o) !== e.data) begin
          fails++;
          $display("FAIL starve_rsp: if_v=%b d_v=%b cycle=%0d if_d=%h d_d=%h required own=%0d cycle=%0d data=%h",
                   b1.if_rsp_valid_o, b1.d_rsp_valid_o, cyc, b1.if_rsp_data_o, b1.d_rsp_data_o,
                   e.own, e.due, e.data);
        end
      end
      if (g < 10) begin
        if (b1.if_req_ready_o && b1.d_req_ready_o) begin
          tests++; fails++; $display("FAIL starve_both_ready: if=1 d=1 required one");
        end
        if (b1.d_req_ready_o) begin
          got[g] = 1'b1; g++; sb.push_back('{OWN_D, memval(32'h400), cyc + 2});
        end else if (b1.if_req_ready_o) begin
          got[g] = 1'b0; g++; sb.push_back('{OWN_IF, memval(32'h300), cyc + 2});
        end
      end
      @(negedge clk);
      n++;
    end
    b1.if_req_valid_i = 1'b0;
    b1.d_req_valid_i  = 1'b0;
    tests++;
    if (got !== expv || g != 10) begin
      fails++; $display("FAIL starve_order: grants=%b count=%0d required %b count=10", got, g, expv);
    end
  endtask

  task automatic test_read_lat3();
    int c, n;
    logic if_rdy_seen;
    logic ok_rd, ok_drsp, ok_ifrsp;
    @(negedge clk);
    b3.if_req_valid_i = 1'b1;
    b3.if_req_addr_i  = 32'h500;
    b3.d_req_valid_i  = 1'b1;
    b3.d_req_we_i     = 1'b0;
    b3.d_req_addr_i   = 32'h40;
    #1;
    tests++;
    if ({b3.d_req_ready_o, b3.if_req_ready_o} !== 2'b10) begin
      fails++; $display("FAIL lat3_priority: d_rdy=%b if_rdy=%b required 1 0", b3.d_req_ready_o, b3.if_req_ready_o);
    end
    c = cyc;
    if_rdy_seen = 1'b0; ok_rd = 1'b0; ok_drsp = 1'b0; ok_ifrsp = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (k == 1) b3.d_req_valid_i = 1'b0;
      if (k == 6) b3.if_req_valid_i = 1'b0;
      if (k <= 4 && b3.if_req_ready_o) if_rdy_seen = 1'b1;
      if (k == 1 && b3.mem_read_en_o && b3.mem_addr_o == 32'h40) ok_rd = 1'b1;
      if (k != 1 && k != 6 && (b3.mem_read_en_o || b3.mem_write_en_o)) ok_rd = 1'b0;
      if (b3.d_rsp_valid_o) ok_drsp = (cyc == c + 4) && (b3.d_rsp_data_o === 32'hCAFE_F00D);
      if (b3.if_rsp_valid_o) ok_ifrsp = (cyc == c + 9) && (b3.if_rsp_data_o === memval(32'h500));
    end
    tests++;
    if (if_rdy_seen) begin fails++; $display("FAIL lat3_if_ready: seen=1 required 0 while busy"); end
    tests++;
    if (!ok_rd) begin fails++; $display("FAIL lat3_strobe: ok=0 required single read strobe at accept+1"); end
    tests++;
    if (!ok_drsp) begin fails++; $display("FAIL lat3_d_rsp: ok=0 required CAFEF00D at accept+4"); end
    tests++;
    if (!ok_ifrsp) begin fails++; $display("FAIL lat3_if_rsp: ok=0 required fetch data at accept+9"); end
  endtask

  task automatic test_withdraw();
    int n;
    logic stray;
    @(negedge clk);
    b1.if_req_valid_i = 1'b1;
    b1.if_req_addr_i  = 32'h800;
    #1;
    n = 0;
    while (!b1.if_req_ready_o && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    b1.if_req_valid_i = 1'b0;
    b1.d_req_valid_i  = 1'b1;
    b1.d_req_we_i     = 1'b1;
    b1.d_req_addr_i   = 32'h900;
    #1;
    tests++;
    if (b1.d_req_ready_o !== 1'b0) begin
      fails++; $display("FAIL withdraw_busy_ready: d_rdy=%b required 0", b1.d_req_ready_o);
    end
    @(negedge clk);
    b1.d_req_valid_i = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (b1.busy_o || b1.mem_write_en_o || b1.mem_read_en_o || b1.d_rsp_valid_o) stray = 1'b1;
    end
    tests++;
    if (stray) begin fails++; $display("FAIL withdraw_side_effect: activity=1 required 0"); end
  endtask

  task automatic test_reset_mid();
    int c2, n, pulses;
    logic ok;
    @(negedge clk);
    b3.if_req_valid_i = 1'b1;
    b3.if_req_addr_i  = 32'h600;
    #1;
    n = 0;
    while (!b3.if_req_ready_o && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    b3.if_req_valid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (b3.busy_o !== 1'b1 || b3.mem_read_en_o !== 1'b0) begin
      fails++; $display("FAIL rstmid_wait: busy=%b rd=%b required 1 0", b3.busy_o, b3.mem_read_en_o);
    end
    rst3 = 1'b0;
    #1;
    tests++;
    if ({b3.busy_o, b3.mem_read_en_o, b3.mem_write_en_o, b3.if_rsp_valid_o, b3.d_rsp_valid_o,
         b3.if_req_ready_o, b3.d_req_ready_o, b3.mem_addr_o, b3.if_rsp_data_o} !== '0) begin
      fails++;
      $display("FAIL rstmid_async: busy=%b addr=%h rsp=%b required all zero",
               b3.busy_o, b3.mem_addr_o, b3.if_rsp_valid_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    b3.if_req_valid_i = 1'b1;
    b3.if_req_addr_i  = 32'h700;
    #1;
    tests++;
    if (b3.if_req_ready_o !== 1'b1) begin
      fails++; $display("FAIL rstmid_new_accept: ready=%b required 1", b3.if_req_ready_o);
    end
    c2 = cyc;
    pulses = 0; ok = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      if (k == 1) b3.if_req_valid_i = 1'b0;
      if (b3.if_rsp_valid_o) begin
        pulses++;
        ok = (cyc == c2 + 4) && (b3.if_rsp_data_o === memval(32'h700));
      end
    end
    tests++;
    if (pulses != 1 || !ok) begin
      fails++; $display("FAIL rstmid_rsp: pulses=%0d ok=%b required 1 pulse of new data at accept+4", pulses, ok);
    end
  endtask

  initial begin
    b1.if_req_valid_i = 1'b0; b1.if_req_addr_i = '0;
    b1.d_req_valid_i  = 1'b0; b1.d_req_we_i = 1'b0; b1.d_req_addr_i = '0; b1.d_req_wdata_i = '0;
    b3.if_req_valid_i = 1'b0; b3.if_req_addr_i = '0;
    b3.d_req_valid_i  = 1'b0; b3.d_req_we_i = 1'b0; b3.d_req_addr_i = '0; b3.d_req_wdata_i = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_fetch();
    test_write();
    test_starvation();
    test_withdraw();
    test_read_lat3();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_port_arbiter
